// File: rtl/vga_pkg.sv
// Shared constants for the VGA picture path: geometry, mode codes and preset origins.
package vga_pkg;

  localparam int unsigned H_RES = 800;
  localparam int unsigned V_RES = 600;
  localparam int unsigned PIC_W = 256;
  localparam int unsigned PIC_H = 256;

  localparam int unsigned X_W   = 11;
  localparam int unsigned Y_W   = 10;
  localparam int unsigned X_MAX = H_RES - PIC_W;
  localparam int unsigned Y_MAX = V_RES - PIC_H;
  localparam int unsigned X_CTR = X_MAX / 2;
  localparam int unsigned Y_CTR = Y_MAX / 2;

  localparam logic [1:0] MODE_STATIC = 2'd0;
  localparam logic [1:0] MODE_BOUNCE = 2'd1;
  localparam logic [1:0] MODE_PAUSE  = 2'd2;

  localparam int unsigned IDX_W    = 3;
  localparam int unsigned N_PRESET = 5;

  // One-hot controller state.
  typedef enum logic [2:0] {
    ST_STATIC = 3'b001,
    ST_BOUNCE = 3'b010,
    ST_PAUSE  = 3'b100
  } state_t;

  // Preset order: centre, TL, TR, BR, BL.
  function automatic logic [X_W-1:0] preset_x(input logic [IDX_W-1:0] idx);
    case (idx)
      3'd1, 3'd4: preset_x = X_W'(0);
      3'd2, 3'd3: preset_x = X_W'(X_MAX);
      default:    preset_x = X_W'(X_CTR);
    endcase
  endfunction

  function automatic logic [Y_W-1:0] preset_y(input logic [IDX_W-1:0] idx);
    case (idx)
      3'd1, 3'd2: preset_y = Y_W'(0);
      3'd3, 3'd4: preset_y = Y_W'(Y_MAX);
      default:    preset_y = Y_W'(Y_CTR);
    endcase
  endfunction

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    next_idx = (idx >= IDX_W'(N_PRESET - 1)) ? IDX_W'(0) : idx + IDX_W'(1);
  endfunction

endpackage

// File: rtl/axis_bounce.sv
// One axis of the picture origin: preset load, or a clamped step that reverses at 0 and MAX.
//  clk, rst_n      clock, async active-low reset (pos <- init_val, dir <- increasing)
//  load, load_val  load pos with load_val (direction kept)
//  step            advance pos by SPEED in the current direction
//  init_val        reset origin (tie to a constant)
//  pos, dir        current position; dir 0 = increasing, 1 = decreasing
module axis_bounce #(
  parameter int unsigned MAX   = 544,
  parameter int unsigned SPEED = 2,
  parameter int unsigned WIDTH = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             step,
  input  logic [WIDTH-1:0] init_val,
  output logic [WIDTH-1:0] pos,
  output logic             dir
);

  localparam int unsigned GW = WIDTH + 1;

  // Guard bit keeps pos+SPEED from wrapping before the clamp compare.
  logic [GW-1:0] pos_g;
  logic [GW-1:0] fwd_g;

  assign pos_g = {1'b0, pos};
  assign fwd_g = pos_g + GW'(SPEED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos <= init_val;
      dir <= 1'b0;
    end else if (load) begin
      pos <= load_val;
    end else if (step) begin
      if (!dir) begin
        if (fwd_g >= GW'(MAX)) begin
          pos <= WIDTH'(MAX);
          dir <= 1'b1;
        end else begin
          pos <= fwd_g[WIDTH-1:0];
        end
      end else begin
        if (pos_g <= GW'(SPEED)) begin
          pos <= '0;
          dir <= 1'b0;
        end else begin
          pos <= pos - WIDTH'(SPEED);
        end
      end
    end
  end

endmodule

// File: rtl/pic_pos_ctrl.sv
// Key-driven placement controller for the ROM picture; origin and mode change only on frame ticks.
//  clk, rst_n  40 MHz pixel clock, async active-low reset
//  key         debounced pulses: [0]=mode, [1]=step/pause
//  vga_vs      vertical sync, same clock domain
//  pic_x/pic_y picture origin
//  mode        0 STATIC, 1 BOUNCE, 2 PAUSE
//  frame_tick  one-cycle pulse per frame edge
module pic_pos_ctrl
  import vga_pkg::*;
#(
  parameter int unsigned SPEED  = 2,
  parameter logic        VS_POL = 1'b0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [1:0]     key,
  input  logic           vga_vs,
  output logic [X_W-1:0] pic_x,
  output logic [Y_W-1:0] pic_y,
  output logic [1:0]     mode,
  output logic           frame_tick
);

  state_t           state;
  logic             vs_q;
  logic             pend_mode;
  logic             pend_step;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_nxt_c;
  logic             load_c;
  logic             step_c;
  logic             dir_x;
  logic             dir_y;

  assign idx_nxt_c = next_idx(idx);
  assign load_c    = frame_tick && (state == ST_STATIC) && !pend_mode && pend_step;
  assign step_c    = frame_tick && (state == ST_BOUNCE) && !pend_mode && !pend_step;

  // Frame edge detector; vs_q resets to the active level so release never fakes a tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q       <= VS_POL;
      frame_tick <= 1'b0;
    end else begin
      vs_q       <= vga_vs;
      frame_tick <= (vs_q != VS_POL) && (vga_vs == VS_POL);
    end
  end

  // Pending key events; mode wins over step, and a key on the tick lands in the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_mode <= 1'b0;
      pend_step <= 1'b0;
    end else if (frame_tick) begin
      pend_mode <= key[0];
      pend_step <= key[1] && !key[0];
    end else begin
      pend_mode <= pend_mode || key[0];
      pend_step <= pend_step || (key[1] && !key[0] && !pend_mode);
    end
  end

  // Mode FSM and preset index, evaluated once per frame tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_STATIC;
      mode  <= MODE_STATIC;
      idx   <= '0;
    end else if (frame_tick) begin
      case (state)
        ST_STATIC: begin
          if (pend_mode) begin
            state <= ST_BOUNCE;
            mode  <= MODE_BOUNCE;
          end else if (pend_step) begin
            idx <= idx_nxt_c;
          end
        end
        ST_BOUNCE: begin
          if (pend_mode) begin
            state <= ST_STATIC;
            mode  <= MODE_STATIC;
          end else if (pend_step) begin
            state <= ST_PAUSE;
            mode  <= MODE_PAUSE;
          end
        end
        ST_PAUSE: begin
          if (pend_mode) begin
            state <= ST_STATIC;
            mode  <= MODE_STATIC;
          end else if (pend_step) begin
            state <= ST_BOUNCE;
            mode  <= MODE_BOUNCE;
          end
        end
        default: begin
          state <= ST_STATIC;
          mode  <= MODE_STATIC;
        end
      endcase
    end
  end

  axis_bounce #(.MAX(X_MAX), .SPEED(SPEED), .WIDTH(X_W)) u_axis_x (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load_c),
    .load_val (preset_x(idx_nxt_c)),
    .step     (step_c),
    .init_val (X_W'(X_CTR)),
    .pos      (pic_x),
    .dir      (dir_x)
  );

  axis_bounce #(.MAX(Y_MAX), .SPEED(SPEED), .WIDTH(Y_W)) u_axis_y (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load_c),
    .load_val (preset_y(idx_nxt_c)),
    .step     (step_c),
    .init_val (Y_W'(Y_CTR)),
    .pos      (pic_y),
    .dir      (dir_y)
  );

  // Direction is internal state only; kept visible for debug probes.
  logic unused_dir_c;
  assign unused_dir_c = dir_x ^ dir_y;

endmodule

// File: tb/tb_pic_pos_ctrl.sv
// Self-checking bench for pic_pos_ctrl: directed scenarios plus random key traffic vs a frame-level model.
module tb_pic_pos_ctrl;

  localparam int S  = 2;
  localparam int XM = 544;
  localparam int YM = 344;

  logic        clk;
  logic        rst_n;
  logic [1:0]  key;
  logic        vga_vs;
  logic [10:0] pic_x;
  logic [9:0]  pic_y;
  logic [1:0]  mode;
  logic        frame_tick;

  pic_pos_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key        (key),
    .vga_vs     (vga_vs),
    .pic_x      (pic_x),
    .pic_y      (pic_y),
    .mode       (mode),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Frame-level model state
  int mx, my, mdx, mdy, midx, mmode;
  bit mpm, mps;
  int px [5] = '{272, 0, 544, 544, 0};
  int py [5] = '{172, 0, 0, 344, 344};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag);
    chk({tag, "_x"}, 32'(pic_x), mx);
    chk({tag, "_y"}, 32'(pic_y), my);
    chk({tag, "_mode"}, 32'(mode), mmode);
  endtask

  task automatic m_reset();
    mx = 272; my = 172; mdx = 1; mdy = 1; midx = 0; mmode = 0; mpm = 0; mps = 0;
  endtask

  task automatic m_press(input logic [1:0] k);
    if (k[0]) mpm = 1;
    else if (k[1] && !mpm) mps = 1;
  endtask

  task automatic m_axis(inout int p, inout int d, input int mxv);
    if (d > 0) begin
      if (p + S >= mxv) begin p = mxv; d = -1; end
      else p = p + S;
    end else begin
      if (p <= S) begin p = 0; d = 1; end
      else p = p - S;
    end
  endtask

  task automatic m_frame();
    if (mpm) begin
      mmode = (mmode == 0) ? 1 : 0;
    end else if (mps) begin
      case (mmode)
        0: begin midx = (midx + 1) % 5; mx = px[midx]; my = py[midx]; end
        1: mmode = 2;
        default: mmode = 1;
      endcase
    end else if (mmode == 1) begin
      m_axis(mx, mdx, XM);
      m_axis(my, mdy, YM);
    end
    mpm = 0;
    mps = 0;
  endtask

  // Single-cycle key pulse; starts and ends on a falling edge.
  task automatic press(input logic [1:0] k);
    key = k;
    @(negedge clk);
    key = 2'b00;
    m_press(k);
  endtask

  // One frame: vs falls, tick one cycle later, outputs move the cycle after; ck is pulsed on the tick.
  task automatic frame(input logic [1:0] ck);
    vga_vs = 1'b0;
    @(negedge clk);
    chk("tick_on", 32'(frame_tick), 1);
    chk_out("pre");
    key = ck;
    m_frame();
    m_press(ck);
    @(negedge clk);
    key = 2'b00;
    chk("tick_off", 32'(frame_tick), 0);
    chk_out("post");
    @(negedge clk);
    vga_vs = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("tick_idle", 32'(frame_tick), 0);
    end
  endtask

  int sx, sy, n;

  initial begin
    rst_n  = 1'b1;
    key    = 2'b00;
    vga_vs = 1'b1;
    #2 rst_n = 1'b0;
    m_reset();
    @(negedge clk);
    @(negedge clk);
    chk_out("rst");
    chk("rst_tick", 32'(frame_tick), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_tick", 32'(frame_tick), 0);

    // 1: idle frames
    for (int i = 0; i < 3; i++) frame(2'b00);
    chk("t1_x", 32'(pic_x), 272);
    chk("t1_y", 32'(pic_y), 172);

    // 2: preset cycle TL, TR, BR, BL, centre
    for (int i = 0; i < 5; i++) begin
      press(2'b10);
      frame(2'b00);
    end
    chk("t2_x", 32'(pic_x), 272);
    chk("t2_y", 32'(pic_y), 172);

    // 3: TL then bounce; 4 steps -> (8,8); run to the right clamp
    press(2'b10);
    frame(2'b00);
    press(2'b01);
    frame(2'b00);
    chk("t3_mode", 32'(mode), 1);
    for (int i = 0; i < 4; i++) frame(2'b00);
    chk("t3_x8", 32'(pic_x), 8);
    chk("t3_y8", 32'(pic_y), 8);
    n = 0;
    while (!(mx == 542 && mdx == 1) && n < 400) begin
      frame(2'b00);
      n++;
    end
    chk("t3_x542", 32'(pic_x), 542);
    frame(2'b00);
    chk("t3_xclamp", 32'(pic_x), 544);
    frame(2'b00);
    chk("t3_xrev", 32'(pic_x), 542);

    // 4: both keys in one cycle -> STATIC; then 3x step in one frame -> one advance
    press(2'b11);
    frame(2'b00);
    chk("t4_mode", 32'(mode), 0);
    press(2'b10);
    press(2'b10);
    press(2'b10);
    frame(2'b00);
    chk("t4_x", 32'(pic_x), 544);
    chk("t4_y", 32'(pic_y), 0);

    // 5: pause freezes position, resume continues
    press(2'b01);
    frame(2'b00);
    frame(2'b00);
    frame(2'b00);
    press(2'b10);
    frame(2'b00);
    chk("t5_mode", 32'(mode), 2);
    sx = mx; sy = my;
    for (int i = 0; i < 4; i++) frame(2'b00);
    chk("t5_frz_x", 32'(pic_x), sx);
    chk("t5_frz_y", 32'(pic_y), sy);
    press(2'b10);
    frame(2'b00);
    chk("t5_resume", 32'(mode), 1);
    frame(2'b00);

    // coincident key on the tick lands in the following frame
    frame(2'b10);
    chk("coinc_hold", 32'(mode), 1);
    frame(2'b00);
    chk("coinc_pause", 32'(mode), 2);
    press(2'b10);
    frame(2'b00);

    // random key traffic
    for (int f = 0; f < 60; f++) begin
      int r;
      logic [1:0] ck;
      r = $urandom_range(0, 5);
      case (r)
        1: press(2'b01);
        2: press(2'b10);
        3: press(2'b11);
        4: begin press(2'b10); press(2'b01); end
        5: begin press(2'b01); press(2'b10); end
        default: @(negedge clk);
      endcase
      ck = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      frame(ck);
    end
    frame(2'b00);

    // 6: reset mid-frame with a pending step in BOUNCE
    if (mmode != 1) begin
      press(2'b01);
      frame(2'b00);
      if (mmode != 1) begin
        press(2'b01);
        frame(2'b00);
      end
    end
    chk("t6_bounce", 32'(mode), 1);
    press(2'b10);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    m_reset();
    chk_out("t6_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    frame(2'b00);
    chk("t6_x", 32'(pic_x), 272);
    chk("t6_y", 32'(pic_y), 172);
    chk("t6_mode", 32'(mode), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
